wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 128 ++++++++++++
 tb/tb_wb_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - three-way write-back arbiter feeding a single register-bank write port
// Define WB_RR_EN for round-robin ALU->LSU->FPU; default build is fixed priority LSU > FPU > ALU.
module wb_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_wb_valid,
  input  logic [4:0]        alu_wb_rd,
  input  logic [DATA_W-1:0] alu_wb_data,
  output logic              alu_wb_ready,
  input  logic              lsu_wb_valid,
  input  logic [4:0]        lsu_wb_rd,
  input  logic [DATA_W-1:0] lsu_wb_data,
  output logic              lsu_wb_ready,
  input  logic              fpu_wb_valid,
  input  logic [4:0]        fpu_wb_rd,
  input  logic [DATA_W-1:0] fpu_wb_data,
  output logic              fpu_wb_ready,
  output logic              wb_signal,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [15:0]       conflict_cnt
);

  localparam logic [1:0] SEL_ALU = 2'd0;
  localparam logic [1:0] SEL_LSU = 2'd1;
  localparam logic [1:0] SEL_FPU = 2'd2;

  logic [2:0]        req;
  logic [2:0]        grant;
  logic              accept;
  logic              multi_req;
  logic [4:0]        sel_rd;
  logic [DATA_W-1:0] sel_data;

  assign req = {fpu_wb_valid, lsu_wb_valid, alu_wb_valid};

`ifdef WB_RR_EN
  logic [1:0] ptr_q;
  logic [1:0] ptr_d;

  // Search starts at the pointer and wraps ALU -> LSU -> FPU -> ALU.
  always_comb begin
    grant = 3'b000;
    case (ptr_q)
      SEL_LSU: begin
        if      (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
        else if (req[0]) grant = 3'b001;
      end
      SEL_FPU: begin
        if      (req[2]) grant = 3'b100;
        else if (req[0]) grant = 3'b001;
        else if (req[1]) grant = 3'b010;
      end
      default: begin
        if      (req[0]) grant = 3'b001;
        else if (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
      end
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant[0])      ptr_d = SEL_LSU;
    else if (grant[1]) ptr_d = SEL_FPU;
    else if (grant[2]) ptr_d = SEL_ALU;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= SEL_ALU;
    else     ptr_q <= ptr_d;
  end
`else
  always_comb begin
    grant = 3'b000;
    if      (req[1]) grant = 3'b010;
    else if (req[2]) grant = 3'b100;
    else if (req[0]) grant = 3'b001;
  end
`endif

  // Readies are forced low while reset is held, even though they are combinational.
  assign alu_wb_ready = grant[0] & ~rst;
  assign lsu_wb_ready = grant[1] & ~rst;
  assign fpu_wb_ready = grant[2] & ~rst;
  assign accept       = |grant;

  assign multi_req = (req[0] & req[1]) | (req[0] & req[2]) | (req[1] & req[2]);

  always_comb begin
    sel_rd   = alu_wb_rd;
    sel_data = alu_wb_data;
    if (grant[1]) begin
      sel_rd   = lsu_wb_rd;
      sel_data = lsu_wb_data;
    end else if (grant[2]) begin
      sel_rd   = fpu_wb_rd;
      sel_data = fpu_wb_data;
    end
  end

  // Writes to x0 are accepted but never reach the register bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_signal <= 1'b0;
      wb_rd     <= 5'd0;
      wb_data   <= '0;
    end else begin
      wb_signal <= accept && (sel_rd != 5'd0);
      if (accept) begin
        wb_rd   <= sel_rd;
        wb_data <= sel_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= 16'd0;
    end else if (multi_req && conflict_cnt != 16'hFFFF) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed table-driven bench for wb_arbiter
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_v, lsu_v, fpu_v;
  logic [4:0]  alu_rd, lsu_rd, fpu_rd;
  logic [31:0] alu_d, lsu_d, fpu_d;
  logic        alu_r, lsu_r, fpu_r;
  logic        wb_signal;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [15:0] conflict_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .alu_wb_valid(alu_v), .alu_wb_rd(alu_rd), .alu_wb_data(alu_d), .alu_wb_ready(alu_r),
    .lsu_wb_valid(lsu_v), .lsu_wb_rd(lsu_rd), .lsu_wb_data(lsu_d), .lsu_wb_ready(lsu_r),
    .fpu_wb_valid(fpu_v), .fpu_wb_rd(fpu_rd), .fpu_wb_data(fpu_d), .fpu_wb_ready(fpu_r),
    .wb_signal(wb_signal), .wb_rd(wb_rd), .wb_data(wb_data), .conflict_cnt(conflict_cnt)
  );

  typedef struct {
    logic [2:0]  valid;   // {fpu, lsu, alu}
    logic [4:0]  rd;
    logic [31:0] data;
    logic [2:0]  exp_ready;
    logic        exp_sig;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] readies();
    return {29'd0, fpu_r, lsu_r, alu_r};
  endfunction

  task automatic idle_inputs();
    alu_v = 0; lsu_v = 0; fpu_v = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1;
    idle_inputs();
    @(negedge clk); rst = 0;
  endtask

  initial begin
    vecs[0] = '{3'b001, 5'd5,  32'hDEADBEEF, 3'b001, 1'b1, 5'd5,  32'hDEADBEEF};
    vecs[1] = '{3'b000, 5'd9,  32'h11111111, 3'b000, 1'b0, 5'd5,  32'hDEADBEEF};
    vecs[2] = '{3'b010, 5'd10, 32'h12345678, 3'b010, 1'b1, 5'd10, 32'h12345678};
    vecs[3] = '{3'b100, 5'd0,  32'hCAFEF00D, 3'b100, 1'b0, 5'd0,  32'hCAFEF00D};
    vecs[4] = '{3'b100, 5'd31, 32'hA5A5A5A5, 3'b100, 1'b1, 5'd31, 32'hA5A5A5A5};
    vecs[5] = '{3'b000, 5'd3,  32'h22222222, 3'b000, 1'b0, 5'd31, 32'hA5A5A5A5};
    vecs[6] = '{3'b010, 5'd0,  32'h00000000, 3'b010, 1'b0, 5'd0,  32'h00000000};
    vecs[7] = '{3'b001, 5'd1,  32'hFFFFFFFF, 3'b001, 1'b1, 5'd1,  32'hFFFFFFFF};

    // Reset with every requester asserting: readies must still be low.
    rst = 1;
    alu_v = 1; lsu_v = 1; fpu_v = 1;
    alu_rd = 5'd4; lsu_rd = 5'd6; fpu_rd = 5'd8;
    alu_d = 32'h1; lsu_d = 32'h2; fpu_d = 32'h3;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", readies(), 32'd0);
    chk("rst_sig", {31'd0, wb_signal}, 32'd0);
    chk("rst_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_data", wb_data, 32'd0);
    chk("rst_cnt", {16'd0, conflict_cnt}, 32'd0);
    @(negedge clk); rst = 0; idle_inputs();

    // Single-requester vectors: grant is independent of arbitration mode.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      alu_v = vecs[i].valid[0]; lsu_v = vecs[i].valid[1]; fpu_v = vecs[i].valid[2];
      alu_rd = vecs[i].rd; lsu_rd = vecs[i].rd; fpu_rd = vecs[i].rd;
      alu_d = vecs[i].data; lsu_d = vecs[i].data; fpu_d = vecs[i].data;
      #1;
      chk($sformatf("vec%0d_ready", i), readies(), {29'd0, vecs[i].exp_ready});
      @(posedge clk); #1;
      idle_inputs();
      chk($sformatf("vec%0d_sig", i), {31'd0, wb_signal}, {31'd0, vecs[i].exp_sig});
      chk($sformatf("vec%0d_rd", i), {27'd0, wb_rd}, {27'd0, vecs[i].exp_rd});
      chk($sformatf("vec%0d_data", i), wb_data, vecs[i].exp_data);
    end
    chk("table_cnt", {16'd0, conflict_cnt}, 32'd0);

    // Three-way contention.
    pulse_reset();
    alu_rd = 5'd1; lsu_rd = 5'd2; fpu_rd = 5'd3;
    alu_d = 32'hA0; lsu_d = 32'hB0; fpu_d = 32'hC0;
    alu_v = 1; lsu_v = 1; fpu_v = 1;
`ifdef WB_RR_EN
    #1 chk("rr_c1_ready", readies(), 32'b001);
    @(posedge clk); #1; alu_v = 0;
    chk("rr_c1_wbrd", {27'd0, wb_rd}, 32'd1);
    chk("rr_c2_ready", readies(), 32'b010);
    @(posedge clk); #1; lsu_v = 0;
    chk("rr_c2_wbrd", {27'd0, wb_rd}, 32'd2);
    chk("rr_c3_ready", readies(), 32'b100);
    @(posedge clk); #1; fpu_v = 0;
    chk("rr_c3_wbrd", {27'd0, wb_rd}, 32'd3);
    chk("rr_c3_sig", {31'd0, wb_signal}, 32'd1);
    chk("rr_cnt", {16'd0, conflict_cnt}, 32'd2);
`else
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("fp_c%0d_ready", c), readies(), 32'b010);
      @(posedge clk); #1;
      chk($sformatf("fp_c%0d_wbrd", c), {27'd0, wb_rd}, 32'd2);
    end
    idle_inputs();
    chk("fp_cnt", {16'd0, conflict_cnt}, 32'd3);
`endif

    // Asynchronous reset landing in an accepting cycle.
    @(negedge clk);
    alu_v = 1; alu_rd = 5'd7; alu_d = 32'h77777777;
    #1 chk("ar_ready_pre", readies(), 32'b001);
    #1 rst = 1;
    #1;
    chk("ar_ready", readies(), 32'd0);
    chk("ar_sig", {31'd0, wb_signal}, 32'd0);
    chk("ar_rd", {27'd0, wb_rd}, 32'd0);
    chk("ar_cnt", {16'd0, conflict_cnt}, 32'd0);
    @(posedge clk);
    @(negedge clk); rst = 0;
    #1 chk("ar_sig_release", {31'd0, wb_signal}, 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    chk("ar_sig_after", {31'd0, wb_signal}, 32'd1);
    chk("ar_rd_after", {27'd0, wb_rd}, 32'd7);

    // Saturation under continuous two-way contention.
    pulse_reset();
    alu_v = 1; lsu_v = 1;
    repeat (65533) @(posedge clk);
    #1 chk("sat_fffd", {16'd0, conflict_cnt}, 32'h0000FFFD);
    @(posedge clk); #1 chk("sat_fffe", {16'd0, conflict_cnt}, 32'h0000FFFE);
    @(posedge clk); #1 chk("sat_ffff", {16'd0, conflict_cnt}, 32'h0000FFFF);
    repeat (3) @(posedge clk);
    #1 chk("sat_hold", {16'd0, conflict_cnt}, 32'h0000FFFF);
    idle_inputs();
    @(posedge clk); #1;
    chk("idle_cnt", {16'd0, conflict_cnt}, 32'h0000FFFF);
    chk("idle_sig", {31'd0, wb_signal}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
